// File: rtl/down_counter.sv
// down_counter -- loadable down-counter / timer.
//
// A value on dn is captured when load is high and then counted down by one
// on every clock where en is high, until zero is reached. tc is a registered
// one-cycle pulse on the edge where q reaches zero. busy is high while the
// FSM is in RUN.
//
// Optional feature (compile-time macro): DOWN_COUNTER_AUTORELOAD_EN
//   undefined (default): reaching zero returns the FSM to IDLE and q holds 0
//                        until the next load.
//   defined            : the FSM stays in RUN at zero, and the next enabled
//                        edge reloads q from the captured load value. This
//                        gives one tc pulse every N+1 enabled cycles.
//
// Ports
//   clk   in   1      clock, rising edge
//   rst   in   1      asynchronous reset, active low
//   load  in   1      synchronous load strobe, highest priority after reset
//   dn    in   WIDTH  load value, unsigned
//   en    in   1      count enable
//   q     out  WIDTH  current count, registered
//   tc    out  1      terminal-count pulse, registered
//   busy  out  1      high while in RUN
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dn,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             tc_r, tc_nxt;

  // Decrement that stops at zero, so the count can never wrap to all-ones.
  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == '0) r = '0;
    else         r = v - 1'b1;
    return r;
  endfunction

  // True when the value is exactly one, i.e. the next decrement ends a count.
  function automatic logic is_last(input logic [WIDTH-1:0] v);
    return (v == WIDTH'(1));
  endfunction

  // ---- state / count registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      reload <= '0;
      tc_r   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      reload <= reload_nxt;
      tc_r   <= tc_nxt;
    end
  end

  // ---- next-state logic: load > decrement > hold ----
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    reload_nxt = reload;
    tc_nxt     = 1'b0;

    if (load) begin
      // A load always restarts cleanly; an aborted count never reports tc.
      cnt_nxt    = dn;
      reload_nxt = dn;
      state_nxt  = (dn != '0) ? RUN : IDLE;
    end else if ((state == RUN) && en) begin
      if (cnt == '0) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        // Zero is only held in RUN for one enabled edge before reloading.
        // reload is never zero here because loading zero forces IDLE.
        cnt_nxt = reload;
`else
        // Unreachable in normal operation; fall back to IDLE defensively.
        state_nxt = IDLE;
`endif
      end else begin
        cnt_nxt = dec_sat(cnt);
        if (is_last(cnt)) begin
          tc_nxt = 1'b1;
`ifndef DOWN_COUNTER_AUTORELOAD_EN
          state_nxt = IDLE;
`endif
        end
      end
    end
  end

  assign q    = cnt;
  assign tc   = tc_r;
  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;
  localparam int WIDTH = 4;

  logic             clk  = 1'b0;
  logic             rst  = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] dn   = '0;
  logic             en   = 1'b0;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .dn   (dn),
    .en   (en),
    .q    (q),
    .tc   (tc),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;
  logic tc_prev = 1'b0;

  // Reference model: a timer holding a count, a running flag and the value
  // last loaded.
  int mq   = 0;
  bit mrun = 1'b0;
  int mrel = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic l, input logic [WIDTH-1:0] d, input logic e,
                       output exp_t x);
    logic t;
    t = 1'b0;
    if (l) begin
      mq   = int'(d);
      mrel = int'(d);
      mrun = (d != '0);
    end else if (mrun && e) begin
      if (mq == 0) begin
        mq = mrel;               // only reachable with autoreload
      end else begin
        mq = mq - 1;
        if (mq == 0) begin
          t = 1'b1;
`ifndef DOWN_COUNTER_AUTORELOAD_EN
          mrun = 1'b0;
`endif
        end
      end
    end
    x.q    = WIDTH'(mq);
    x.tc   = t;
    x.busy = mrun;
  endtask

  task automatic drive(input logic l, input logic [WIDTH-1:0] d, input logic e);
    exp_t x;
    @(negedge clk);
    load = l;
    dn   = d;
    en   = e;
    model(l, d, e, x);
    sb.push_back(x);
    mon_en = 1'b1;
  endtask

  // Monitor: after every rising edge, pop the expected response and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty actual=q%0d required=an expected entry", q);
        end else begin
          e = sb.pop_front();
          check("q", 32'(q), 32'(e.q));
          check("tc", 32'(tc), 32'(e.tc));
          check("busy", 32'(busy), 32'(e.busy));
          check("tc_two_cycles", 32'(tc & tc_prev), 32'd0);
        end
        tc_prev = tc;
      end
    end
  end

  initial begin
    // Reset state while rst is low.
    #2;
    check("reset_q", 32'(q), 32'd0);
    check("reset_tc", 32'(tc), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    #1 rst = 1'b1;

    // Basic count of 7, then a few idle cycles at zero.
    drive(1'b1, 4'd7, 1'b1);
    repeat (9) drive(1'b0, 4'd0, 1'b1);

    // Enable gating: hold at 4 for three cycles.
    drive(1'b1, 4'd7, 1'b1);
    repeat (3) drive(1'b0, 4'd0, 1'b1);
    repeat (3) drive(1'b0, 4'd0, 1'b0);
    repeat (6) drive(1'b0, 4'd0, 1'b1);

    // Restart at q=3 with 9.
    drive(1'b1, 4'd7, 1'b1);
    repeat (4) drive(1'b0, 4'd0, 1'b1);
    drive(1'b1, 4'd9, 1'b1);
    repeat (11) drive(1'b0, 4'd0, 1'b1);

    // Zero load.
    drive(1'b1, 4'd0, 1'b1);
    repeat (3) drive(1'b0, 4'd0, 1'b1);

    // Load collides with the final decrement.
    drive(1'b1, 4'd3, 1'b1);
    repeat (2) drive(1'b0, 4'd0, 1'b1);
    drive(1'b1, 4'd5, 1'b1);
    repeat (7) drive(1'b0, 4'd0, 1'b1);

    // Maximum load value with idle-state enable toggling.
    drive(1'b1, 4'd15, 1'b1);
    repeat (17) drive(1'b0, 4'd0, 1'b1);
    repeat (2) drive(1'b0, 4'd0, 1'b0);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    // Periodic tc: 2,1,0,2,1,0,...
    drive(1'b1, 4'd2, 1'b1);
    repeat (10) drive(1'b0, 4'd0, 1'b1);
`endif

    // Asynchronous reset mid-count at q=5.
    drive(1'b1, 4'd7, 1'b1);
    repeat (2) drive(1'b0, 4'd0, 1'b1);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    check("pre_reset_q", 32'(q), 32'd5);
    rst = 1'b0;
    #1;
    check("async_reset_q", 32'(q), 32'd0);
    check("async_reset_tc", 32'(tc), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    #1;
    rst     = 1'b1;
    mq      = 0;
    mrun    = 1'b0;
    mrel    = 0;
    tc_prev = 1'b0;
    drive(1'b1, 4'd3, 1'b1);
    repeat (5) drive(1'b0, 4'd0, 1'b1);

    // Randomised traffic.
    repeat (600) begin
      drive(($urandom_range(0, 9) == 0),
            WIDTH'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));
    end

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/down_counter.md
# down_counter

Loadable down-counter/timer: the decrementing companion to the team's loadable up-counter. A value presented on `dn` is captured on `load` and counted down to zero, one step per enabled clock. `tc` pulses for one cycle at zero. It sits beside the up-counter in the flip-flop/counter library and serves as the timeout and delay generator for surrounding control logic.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `load`  input  1  synchronous load strobe; captures `dn` and starts a count.
- `dn`  input  WIDTH  load value, unsigned.
- `en`  input  1  count enable; decrement only when high.
- `q`  output  WIDTH  current count, registered.
- `tc`  output  1  terminal-count pulse, registered, one cycle wide.
- `busy`  output  1  high while in RUN.

## Operation
- Reset, asynchronous, takes effect immediately regardless of clock:
  - `q`=0, `tc`=0, `busy`=0.
  - State IDLE; internal reload register cleared to 0.
- FSM has two states: IDLE and RUN. `busy` is 1 exactly in RUN.
- Priority at each edge: reset > `load` > decrement > hold.
- Load with `dn`≠0, in any state:
  - `q`←`dn`, reload register←`dn`, state←RUN, `tc`←0.
  - Load during RUN restarts the count. No `tc` is issued for the aborted count.
- Load with `dn`=0:
  - `q`←0, reload register←0, state←IDLE, `tc`←0.
  - No terminal count is generated.
- RUN, `en`=1, `q`>1: `q`←`q`−1, `tc`←0.
- RUN, `en`=1, `q`=1: `q`←0, `tc`←1, then end-of-count handling (see Configuration).
- RUN, `en`=0: `q` holds, `tc`←0.
- IDLE: `q` holds, `tc`←0. `en` has no effect.
- Arithmetic is unsigned modulo 2^WIDTH. `q` never decrements below 0, so no underflow or wrap occurs.
- `tc` is never high for two consecutive cycles.

## Timing
- Load-to-output latency: `q`=`dn` is visible after the load edge (1 cycle).
- Load-to-zero: with `dn`=N≥1 and `en` held high, `q` reaches 0 and `tc`=1 on the Nth edge after the load edge.
- `tc` deasserts on the following edge.
- `en` low cycles stretch the count one-for-one.
- `load` coincident with `q`=1 and `en`=1: the load wins, `tc` stays 0.
- Reset deassertion is asynchronous. The first `load` is honoured on the first rising edge with `rst`=1.

## Configuration
- Macro: `DOWN_COUNTER_AUTORELOAD_EN`.
- Undefined (default):
  - At the edge where `q` becomes 0, state←IDLE and `busy`←0 together with `tc`←1.
  - `q` holds 0 until the next `load`.
- Defined:
  - State stays RUN at the zero edge.
  - On the next edge with `en`=1 and `q`=0: `q`←reload register, `tc`←0.
  - This gives a periodic `tc`, one pulse every N+1 enabled cycles.
  - A reload register of 0 never occurs in RUN, because loading 0 forces IDLE.

## Test plan
- Reset: drive `rst`=0 mid-count at `q`=5 → `q`=0, `tc`=0, `busy`=0 immediately, without waiting for a clock edge. Then release reset, load 3 with `en`=1 → the count runs normally.
- Basic count, WIDTH=4:
  - Load 4'd7 with `en`=1 → `q`=7,6,5,4,3,2,1,0 on successive edges.
  - `tc`=1 only in the cycle with `q`=0, 7 edges after the load edge.
  - `busy` falls with `tc` (autoreload off).
- Enable gating: during a count of 7, drop `en` for 3 cycles at `q`=4 → `q` holds 4 for 3 cycles, then resumes 3,2,1,0. `tc` arrives 3 cycles later than in the basic count.
- Restart: at `q`=3, load 4'd9 → `q`=9 next edge, no `tc`. Then count 9 down to 0 with a single `tc`.
- Zero load and collision:
  - Load 4'd0 → `q`=0, `busy`=0, `tc` never asserted.
  - Assert `load` (4'd5) at `q`=1 with `en`=1 → `q`=5, `tc`=0.
- With `DOWN_COUNTER_AUTORELOAD_EN`: load 4'd2, `en`=1 → `q` = 2,1,0,2,1,0,2…
  - `tc` high at each 0, period 3 cycles.
  - `busy` stays 1 throughout.
